// File: rtl/core_run_pkg.sv
// ---------------------------------------------------------------------------
// core_run_pkg
// Shared types and parameter defaults for the core run controller:
//   run_state_e  - controller FSM states
//   err_code_e   - reason a run ended in failure
//   DEF_*        - default values for the controller parameters
// ---------------------------------------------------------------------------
package core_run_pkg;

    localparam int unsigned DEF_IMEM_WORDS     = 64;
    localparam logic [31:0] DEF_PASS_PC        = 32'h0000_0014;
    localparam logic [31:0] DEF_ERR_PC         = 32'h0000_004C;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 70;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } run_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_HIT_PC   = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_code_e;

endpackage

// File: rtl/core_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_run_ctrl_if
// Program-load handshake plus the instruction-memory write port it feeds.
//   ld_valid / ld_data / ld_last  - load word offered by the loader
//   ld_ready                      - controller accepts the offered word
//   imem_we / imem_addr / imem_wdata - instruction-memory write port
// master: loader side (drives the load word, observes the rest)
// slave : controller side
// ---------------------------------------------------------------------------
interface core_run_ctrl_if
    import core_run_pkg::*;
#(
    parameter int ADDR_W = $clog2(DEF_IMEM_WORDS)
);
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/core_run_ctrl_run_monitor.sv
// ---------------------------------------------------------------------------
// run_monitor
// Run statistics and exit detection for the core run controller.
//   clk, reset            - clock, async active-high reset
//   run_start             - clear statistics (run about to begin)
//   run_active            - core is running this cycle
//   pc, mem_write, data_addr, write_data - observed core activity
//   cycle_count, last_addr, last_data    - statistics
//   hit_pass, hit_err, hit_timeout       - exit conditions for this cycle
// ---------------------------------------------------------------------------
module run_monitor
    import core_run_pkg::*;
#(
    parameter logic [31:0] PASS_PC        = DEF_PASS_PC,
    parameter logic [31:0] ERR_PC         = DEF_ERR_PC,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_start,
    input  logic        run_active,
    input  logic [31:0] pc,
    input  logic        mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic [31:0] cycle_count,
    output logic [31:0] last_addr,
    output logic [31:0] last_data,
    output logic        hit_pass,
    output logic        hit_err,
    output logic        hit_timeout
);

    localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] last_addr_q, last_addr_d;
    logic [31:0] last_data_q, last_data_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        last_addr_d   = last_addr_q;
        last_data_d   = last_data_q;
        if (run_start) begin
            cycle_count_d = '0;
            last_addr_d   = '0;
            last_data_d   = '0;
        end else if (run_active) begin
            cycle_count_d = cycle_count_q + 32'd1;
            if (mem_write) begin
                last_addr_d = data_addr;
                last_data_d = write_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q <= '0;
            last_addr_q   <= '0;
            last_data_q   <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            last_addr_q   <= last_addr_d;
            last_data_q   <= last_data_d;
        end
    end

    // The count seen here is the number of RUN cycles already completed, so
    // matching TIMEOUT_CYCLES-1 ends the run on its TIMEOUT_CYCLES-th cycle.
    assign hit_pass    = (pc == PASS_PC);
    assign hit_err     = (pc == ERR_PC);
    assign hit_timeout = (cycle_count_q == LAST_CYCLE);

    assign cycle_count = cycle_count_q;
    assign last_addr   = last_addr_q;
    assign last_data   = last_data_q;

endmodule

// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
// Loads a program into instruction memory, holds the single-cycle core in
// reset until started, then watches the PC for pass/error/timeout.
//   clk, reset              - clock, async active-high reset
//   ld_if (slave)           - load handshake + instruction-memory write port
//   start, clear            - begin a loaded run / return from DONE to IDLE
//   core_reset              - reset to the core (low only while running)
//   pc, mem_write, data_addr, write_data - core activity monitor
//   done, pass, fail, err_code           - run outcome
//   cycle_count, last_addr, last_data    - run statistics
// ---------------------------------------------------------------------------
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int          IMEM_WORDS     = DEF_IMEM_WORDS,
    parameter logic [31:0] PASS_PC        = DEF_PASS_PC,
    parameter logic [31:0] ERR_PC         = DEF_ERR_PC,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    core_run_ctrl_if.slave   ld_if,
    input  logic             start,
    input  logic             clear,
    output logic             core_reset,
    input  logic [31:0]      pc,
    input  logic             mem_write,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      write_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       err_code,
    output logic [31:0]      cycle_count,
    output logic [31:0]      last_addr,
    output logic [31:0]      last_data
);

    localparam int ADDR_W = $clog2(IMEM_WORDS);
    // One extra bit so the pointer can hold a full word count.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(IMEM_WORDS - 1);

    run_state_e      state_q, state_d;
    logic [ADDR_W:0] ptr_q, ptr_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    err_code_e       err_q, err_d;

    logic            accept;
    logic            run_start;
    logic            hit_pass, hit_err, hit_timeout;

    assign ld_if.ld_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    // Gate with reset so no write strobe escapes while reset is held.
    assign accept           = ld_if.ld_valid && ld_if.ld_ready && !reset;
    assign ld_if.imem_we    = accept;
    assign ld_if.imem_addr  = ptr_q[ADDR_W-1:0];
    assign ld_if.imem_wdata = ld_if.ld_data;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        err_d     = err_q;
        run_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ld_if.ld_last) begin
                        state_d = ST_ARMED;
                    end else if (ptr_q == LAST_WORD) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_ARMED: begin
                if (start) begin
                    state_d   = ST_RUN;
                    run_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (hit_pass) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b1;
                end else if (hit_err) begin
                    state_d = ST_DONE;
                    fail_d  = 1'b1;
                    err_d   = ERR_HIT_PC;
                end else if (hit_timeout) begin
                    state_d = ST_DONE;
                    fail_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    err_d   = ERR_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
        end
    end

    run_monitor #(
        .PASS_PC        (PASS_PC),
        .ERR_PC         (ERR_PC),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_monitor (
        .clk         (clk),
        .reset       (reset),
        .run_start   (run_start),
        .run_active  (state_q == ST_RUN),
        .pc          (pc),
        .mem_write   (mem_write),
        .data_addr   (data_addr),
        .write_data  (write_data),
        .cycle_count (cycle_count),
        .last_addr   (last_addr),
        .last_data   (last_data),
        .hit_pass    (hit_pass),
        .hit_err     (hit_err),
        .hit_timeout (hit_timeout)
    );

    assign core_reset = (state_q != ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign err_code   = err_q;

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter IMEM_WORDS, default 64, number of instruction-memory words loadable (power of two).
REQ-002 Parameter PASS_PC, default 32'h00000014, PC value that ends a run as pass.
REQ-003 Parameter ERR_PC, default 32'h0000004C, PC value that ends a run as error.
REQ-004 Parameter TIMEOUT_CYCLES, default 70, maximum RUN cycles before timeout.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 ld_valid  in  1  load word offered.
REQ-008 ld_data  in  32  instruction word.
REQ-009 ld_last  in  1  offered word is the final program word.
REQ-010 ld_ready  out  1  controller accepts load word.
REQ-011 start  in  1  begin execution of loaded program.
REQ-012 clear  in  1  return from DONE to IDLE.
REQ-013 imem_we  out  1  instruction-memory write strobe.
REQ-014 imem_addr  out  $clog2(IMEM_WORDS)  instruction-memory word address.
REQ-015 imem_wdata  out  32  instruction-memory write data.
REQ-016 core_reset  out  1  reset to the single-cycle core.
REQ-017 pc  in  32  core program counter.
REQ-018 mem_write  in  1, data_addr  in  32, write_data  in  32  core data-store monitor.
REQ-019 done  out  1; pass  out  1; fail  out  1; err_code  out  2 (0 none, 1 ERR_PC, 2 timeout, 3 load overflow).
REQ-020 cycle_count  out  32; last_addr  out  32; last_data  out  32  run statistics.

Function
REQ-021 FSM states: IDLE, LOAD, ARMED, RUN, DONE; core_reset SHALL be 1 in every state except RUN.
REQ-022 ld_ready SHALL be 1 only in IDLE and LOAD; a beat is accepted when ld_valid & ld_ready.
REQ-023 On acceptance: imem_we=1 same cycle, imem_addr=word pointer, imem_wdata=ld_data (zero latency); pointer increments next edge.
REQ-024 IDLE: first accepted beat writes address 0 and moves to LOAD (to ARMED if ld_last).
REQ-025 LOAD: accepted beat with ld_last moves to ARMED; pointer then holds word count.
REQ-026 Accepted beat at address IMEM_WORDS-1 without ld_last: word is written, then DONE with fail=1, err_code=3.
REQ-027 start is ignored in IDLE, LOAD, RUN, DONE; in ARMED it moves to RUN next edge and clears cycle_count, last_addr, last_data.
REQ-028 RUN: cycle_count increments every cycle; if mem_write=1, last_addr/last_data capture data_addr/write_data.
REQ-029 RUN exit checks each cycle, priority pass > error > timeout: pc==PASS_PC -> DONE pass; pc==ERR_PC -> DONE fail code 1; cycle_count==TIMEOUT_CYCLES-1 -> DONE fail code 2.
REQ-030 DONE: done=1, core_reset=1, flags and statistics hold; clear moves to IDLE, zeroes pointer, flags, err_code.
REQ-031 clear outside DONE SHALL be ignored; pass and fail SHALL never both be 1.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, core_reset=1, ld_ready=1, imem_we=0, pointer=0, done=pass=fail=0, err_code=0, all counters/captures 0, including mid-load or mid-run.

Structure
REQ-033 Package core_run_pkg SHALL hold the state enum, err_code enum, and parameter defaults.
REQ-034 One sub-module run_monitor SHALL implement cycle counter, store capture and PC/timeout comparison; FSM stays in core_run_ctrl.

Verification
REQ-035 Load 6 words (last on 6th), start -> imem_we on addresses 0..5, ARMED, RUN; pc reaches 32'h14 -> done=1, pass=1, err_code=0.
REQ-036 RUN with pc reaching 32'h4C -> done=1, fail=1, err_code=1, core_reset=1 next cycle.
REQ-037 RUN with pc never matching -> DONE after exactly 70 RUN cycles, err_code=2, cycle_count=70.
REQ-038 Stream 64 words without ld_last -> all 64 written, fail=1, err_code=3, ld_ready=0.
REQ-039 Store data_addr=100, write_data=25 during RUN then pass -> last_addr=100, last_data=25; clear -> IDLE, flags 0.
REQ-040 Assert reset mid-RUN and mid-LOAD -> all outputs at reset values without waiting for clk edge.
